// File: rtl/avalon_master_pattern_tester.sv
// Avalon-MM master test engine: writes an incrementing pattern over a word
// range, reads it back and counts mismatches. Modes: write, read-check,
// write-then-verify. All outputs are registered.
module avalon_master_pattern_tester #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic [ADDR_WIDTH-1:0]   avm_address,
  output logic                    avm_read,
  output logic                    avm_write,
  output logic [DATA_WIDTH-1:0]   avm_writedata,
  output logic [DATA_WIDTH/8-1:0] avm_byteenable,
  input  logic                    avm_waitrequest,
  input  logic [DATA_WIDTH-1:0]   avm_readdata,
  input  logic                    avm_readdatavalid,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BE_WIDTH);

  localparam logic [1:0] MODE_WRITE  = 2'b00;
  localparam logic [1:0] MODE_READ   = 2'b01;
  localparam logic [1:0] MODE_VERIFY = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT,
    FIN
  } state_t;

  state_t                  state;
  logic [IDX_WIDTH-1:0]    idx;
  logic [1:0]              mode_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [DATA_WIDTH-1:0]   seed_q;
  logic                    last_word;

  // Current word is the final one of the range
  assign last_word = (idx == LAST_IDX);

  // Run sequencer; avm_writedata doubles as the expected pattern (seed + i) during reads
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      mode_q         <= '0;
      base_q         <= '0;
      seed_q         <= '0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q         <= mode;
            base_q         <= base_addr;
            seed_q         <= seed;
            idx            <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            avm_address    <= base_addr;
            avm_writedata  <= seed;
            busy           <= 1'b1;
            case (mode)
              MODE_WRITE, MODE_VERIFY: begin
                state          <= WR;
                avm_write      <= 1'b1;
                avm_byteenable <= '1;
              end
              MODE_READ: begin
                state          <= RD;
                avm_read       <= 1'b1;
                avm_byteenable <= '1;
              end
              default: state <= FIN;
            endcase
          end
        end

        WR: begin
          if (!avm_waitrequest) begin
            if (last_word) begin
              idx       <= '0;
              avm_write <= 1'b0;
              if (mode_q == MODE_VERIFY) begin
                state         <= RD;
                avm_read      <= 1'b1;
                avm_address   <= base_q;
                avm_writedata <= seed_q;
              end else begin
                state          <= FIN;
                avm_byteenable <= '0;
              end
            end else begin
              idx           <= idx + IDX_WIDTH'(1);
              avm_address   <= avm_address + ADDR_STEP;
              avm_writedata <= avm_writedata + DATA_WIDTH'(1);
            end
          end
        end

        RD: begin
          if (!avm_waitrequest) begin
            state          <= RD_WAIT;
            avm_read       <= 1'b0;
            avm_byteenable <= '0;
          end
        end

        RD_WAIT: begin
          if (avm_readdatavalid) begin
            if (avm_readdata != avm_writedata) begin
              if (err_count != '1) begin
                err_count <= err_count + CNT_WIDTH'(1);
              end
              if (err_count == '0) begin
                first_err_addr <= avm_address;
              end
            end
            if (last_word) begin
              state <= FIN;
            end else begin
              state          <= RD;
              idx            <= idx + IDX_WIDTH'(1);
              avm_address    <= avm_address + ADDR_STEP;
              avm_writedata  <= avm_writedata + DATA_WIDTH'(1);
              avm_read       <= 1'b1;
              avm_byteenable <= '1;
            end
          end
        end

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
